// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access sequencer: RV32I size
// encodings, FSM states and base byte-enable patterns.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Stores reuse the signed-load encodings for their sizes.
  localparam logic [2:0] F3_SB = F3_LB;
  localparam logic [2:0] F3_SH = F3_LH;
  localparam logic [2:0] F3_SW = F3_LW;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: byte enables, replicated store data,
// legality/alignment checks and extraction of sign/zero-extended load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        wen,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_lane,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] load_data
);

  logic [15:0] lane;

  assign lane = 16'(rdata >> {addr_lo, 3'b000});

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    mask       = '0;
    wdata_lane = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    unique case (funct3)
      F3_LB, F3_LBU: begin
        mask       = MASK_B << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        illegal    = wen && (funct3 == F3_LBU);
      end
      F3_LH, F3_LHU: begin
        mask       = MASK_H << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
        illegal    = wen && (funct3 == F3_LHU);
      end
      F3_LW: begin
        mask       = MASK_W;
        wdata_lane = wdata;
        misaligned = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    load_data = '0;
    unique case (funct3)
      F3_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
      F3_LBU:  load_data = {24'h0, lane[7:0]};
      F3_LH:   load_data = {{16{lane[15]}}, lane};
      F3_LHU:  load_data = {16'h0, lane};
      F3_LW:   load_data = rdata;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle load/store sequencer between the MEM stage and the data
// memory: one request at a time, pipeline stall, timeout and fault reporting.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_wen,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_req_ready,
  output logic        o_stall,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_fault,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_valid,
  input  logic [31:0] i_dmem_rdata
);

  state_t            state_q, state_d;
  logic              wen_q, fault_q;
  logic [2:0]        f3_q;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              in_idle, timeout, req_bad;
  logic              al_wen, al_misaligned, al_illegal;
  logic [2:0]        al_f3;
  logic [1:0]        al_addr;
  logic [31:0]       al_wdata, al_wdata_lane, al_load;
  logic [3:0]        al_mask;

  assign in_idle = (state_q == ST_IDLE);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // In IDLE the checker looks at the incoming request so a bad one never reaches ISSUE.
  assign al_wen   = in_idle ? i_req_wen         : wen_q;
  assign al_f3    = in_idle ? i_req_funct3      : f3_q;
  assign al_addr  = in_idle ? i_req_addr[1:0]   : addr_q[1:0];
  assign al_wdata = in_idle ? i_req_wdata       : wdata_q;
  assign req_bad  = al_misaligned | al_illegal;

  dmem_lane_align u_align (
    .funct3     (al_f3),
    .wen        (al_wen),
    .addr_lo    (al_addr),
    .wdata      (al_wdata),
    .rdata      (i_dmem_rdata),
    .mask       (al_mask),
    .wdata_lane (al_wdata_lane),
    .misaligned (al_misaligned),
    .illegal    (al_illegal),
    .load_data  (al_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_req_valid) state_d = req_bad ? ST_RESP : ST_ISSUE;
      ST_ISSUE: begin
        if (i_dmem_ready) state_d = wen_q ? ST_RESP : ST_WAIT;
        else if (timeout) state_d = ST_RESP;
      end
      ST_WAIT:  if (i_dmem_valid || timeout) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (i_req_valid) begin
          wen_q   <= i_req_wen;
          f3_q    <= i_req_funct3;
          addr_q  <= i_req_addr;
          wdata_q <= i_req_wdata;
          fault_q <= req_bad;
          rdata_q <= '0;
          cnt_q   <= '0;
        end
        ST_ISSUE: begin
          cnt_q <= cnt_q + 1'b1;
          if (!i_dmem_ready && timeout) fault_q <= 1'b1;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (i_dmem_valid) rdata_q <= al_load;
          else if (timeout) fault_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_req_ready  = in_idle;
    o_stall      = (in_idle && i_req_valid) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    o_resp_valid = (state_q == ST_RESP);
    o_fault      = (state_q == ST_RESP) && fault_q;
    o_resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    o_dmem_ren   = 1'b0;
    o_dmem_wen   = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_wdata = '0;
    o_dmem_mask  = '0;
    if (state_q == ST_ISSUE) begin
      o_dmem_ren   = ~wen_q;
      o_dmem_wen   = wen_q;
      o_dmem_addr  = {addr_q[31:2], 2'b00};
      o_dmem_wdata = al_wdata_lane;
      o_dmem_mask  = al_mask;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus random
// transactions compared against a behavioural model of the load/store rules.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int TO_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_n, rst_to_n;
  logic        i_req_valid, i_req_wen;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        i_dmem_ready, i_dmem_valid;
  logic [31:0] i_dmem_rdata;

  logic        o_req_ready, o_stall, o_resp_valid, o_fault;
  logic [31:0] o_resp_rdata, o_dmem_addr, o_dmem_wdata;
  logic        o_dmem_ren, o_dmem_wen;
  logic [3:0]  o_dmem_mask;

  logic        to_req_ready, to_stall, to_resp_valid, to_fault;
  logic [31:0] to_resp_rdata, to_dmem_addr, to_dmem_wdata;
  logic        to_dmem_ren, to_dmem_wen;
  logic [3:0]  to_dmem_mask;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] mem [16];

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_wen(i_req_wen), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_req_ready(o_req_ready), .o_stall(o_stall), .o_resp_valid(o_resp_valid),
    .o_resp_rdata(o_resp_rdata), .o_fault(o_fault),
    .o_dmem_addr(o_dmem_addr), .o_dmem_ren(o_dmem_ren), .o_dmem_wen(o_dmem_wen),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_mask(o_dmem_mask),
    .i_dmem_ready(i_dmem_ready), .i_dmem_valid(i_dmem_valid), .i_dmem_rdata(i_dmem_rdata)
  );

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO_CYCLES), .CNT_W(8)) dut_to (
    .clk(clk), .rst_n(rst_to_n),
    .i_req_valid(i_req_valid), .i_req_wen(i_req_wen), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_req_ready(to_req_ready), .o_stall(to_stall), .o_resp_valid(to_resp_valid),
    .o_resp_rdata(to_resp_rdata), .o_fault(to_fault),
    .o_dmem_addr(to_dmem_addr), .o_dmem_ren(to_dmem_ren), .o_dmem_wen(to_dmem_wen),
    .o_dmem_wdata(to_dmem_wdata), .o_dmem_mask(to_dmem_mask),
    .i_dmem_ready(i_dmem_ready), .i_dmem_valid(i_dmem_valid), .i_dmem_rdata(i_dmem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules, stated in terms of access size in bytes.
  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_bad(input logic wen, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (wen && f3 > 3'd2) return 1'b1;
    return (a % size_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << size_bytes(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (size_bytes(f3))
      1:       return {4{w[7:0]}};
      2:       return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    logic [31:0] t;
    t = word >> (8 * (a % 4));
    case (f3)
      3'b000:  return 32'($signed(t[7:0]));
      3'b001:  return 32'($signed(t[15:0]));
      3'b100:  return {24'h0, t[7:0]};
      3'b101:  return {16'h0, t[15:0]};
      default: return word;
    endcase
  endfunction

  // Drives one request and plays the memory side with the given delays.
  task automatic run_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int rdly, input int vdly,
                         input logic [31:0] word, output int resp_k, output logic flt,
                         output logic [31:0] rd, output logic seen, output logic ok,
                         output logic [3:0] mask_seen, output logic [31:0] wdata_seen);
    int rc, vc;
    logic got;
    rc = 0; vc = 0; got = 1'b0;
    resp_k = -1; flt = 1'bx; rd = 'x; seen = 1'b0; ok = 1'b1;
    mask_seen = '0; wdata_seen = '0;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_wen = wen; i_req_funct3 = f3;
    i_req_addr = addr; i_req_wdata = wd;
    #1;
    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    check("stall_at_accept", 32'(o_stall), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      i_req_valid = 1'b0; i_dmem_ready = 1'b0; i_dmem_valid = 1'b0; i_dmem_rdata = $urandom;
      #1;
      if (o_resp_valid) begin
        resp_k = k; flt = o_fault; rd = o_resp_rdata;
        break;
      end
      if (!o_stall) ok = 1'b0;
      if (o_dmem_ren || o_dmem_wen) begin
        if (got) ok = 1'b0;
        seen = 1'b1; mask_seen = o_dmem_mask; wdata_seen = o_dmem_wdata;
        if (o_dmem_wen !== wen || o_dmem_ren !== ~wen ||
            o_dmem_addr !== {addr[31:2], 2'b00} || o_dmem_mask !== ref_mask(f3, addr) ||
            (wen && o_dmem_wdata !== ref_wdata(f3, wd)))
          ok = 1'b0;
        if (rc == rdly) begin i_dmem_ready = 1'b1; got = 1'b1; end
        rc++;
      end else if (got && !wen) begin
        if (vc == vdly) begin i_dmem_valid = 1'b1; i_dmem_rdata = word; end
        vc++;
      end
    end
  endtask

  initial begin
    int k; logic flt, seen, ok, norsp; logic [31:0] rd, wseen; logic [3:0] mseen;
    logic wen; logic [2:0] f3; logic [31:0] addr, wd, word; int rdly, vdly, exp_k; logic bad;

    rst_n = 1'b0; rst_to_n = 1'b0;
    i_req_valid = 0; i_req_wen = 0; i_req_funct3 = 0; i_req_addr = 0; i_req_wdata = 0;
    i_dmem_ready = 0; i_dmem_valid = 0; i_dmem_rdata = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    #12;
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    check("rst_strobes", 32'({o_dmem_ren, o_dmem_wen}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // SW 0x100
    run_txn(1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, k, flt, rd, seen, ok, mseen, wseen);
    check("sw_resp_cycle", 32'(k), 32'd2);
    check("sw_fault", 32'(flt), 32'd0);
    check("sw_rdata", rd, 32'h0);
    check("sw_mask", 32'(mseen), 32'hF);
    check("sw_wdata", wseen, 32'hDEADBEEF);
    check("sw_bus_ok", 32'(ok), 32'd1);
    @(negedge clk); #1;
    check("sw_resp_one_cycle", 32'(o_resp_valid), 32'd0);

    // Loads from 0x80FF_0000
    run_txn(1'b0, F3_LB, 32'h103, 32'h0, 0, 0, 32'h80FF_0000, k, flt, rd, seen, ok, mseen, wseen);
    check("lb_resp_cycle", 32'(k), 32'd3);
    check("lb_mask", 32'(mseen), 32'h8);
    check("lb_rdata", rd, 32'hFFFFFF80);
    check("lb_bus_ok", 32'(ok), 32'd1);
    run_txn(1'b0, F3_LBU, 32'h103, 32'h0, 0, 0, 32'h80FF_0000, k, flt, rd, seen, ok, mseen, wseen);
    check("lbu_rdata", rd, 32'h00000080);
    run_txn(1'b0, F3_LHU, 32'h102, 32'h0, 0, 0, 32'h80FF_0000, k, flt, rd, seen, ok, mseen, wseen);
    check("lhu_rdata", rd, 32'h000080FF);
    check("lhu_mask", 32'(mseen), 32'hC);

    // Misaligned LW
    run_txn(1'b0, F3_LW, 32'h101, 32'h0, 0, 0, 32'h0, k, flt, rd, seen, ok, mseen, wseen);
    check("mis_resp_cycle", 32'(k), 32'd1);
    check("mis_fault", 32'(flt), 32'd1);
    check("mis_rdata", rd, 32'h0);
    check("mis_no_strobe", 32'(seen), 32'd0);

    // SH with five wait states on ready
    run_txn(1'b1, F3_SH, 32'h06, 32'h1234, 5, 0, 32'h0, k, flt, rd, seen, ok, mseen, wseen);
    check("sh_resp_cycle", 32'(k), 32'd7);
    check("sh_mask", 32'(mseen), 32'hC);
    check("sh_wdata", wseen, 32'h12341234);
    check("sh_bus_stable", 32'(ok), 32'd1);
    check("sh_fault", 32'(flt), 32'd0);

    // Random traffic against a small memory model
    for (int n = 0; n < 60; n++) begin
      wen = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wd = $urandom;
      rdly = $urandom_range(0, 3); vdly = $urandom_range(0, 3);
      word = mem[addr[5:2]];
      bad = ref_bad(wen, f3, addr);
      exp_k = bad ? 1 : (wen ? 2 + rdly : 3 + rdly + vdly);
      run_txn(wen, f3, addr, wd, rdly, vdly, word, k, flt, rd, seen, ok, mseen, wseen);
      check($sformatf("rnd%0d_resp_cycle", n), 32'(k), 32'(exp_k));
      check($sformatf("rnd%0d_fault", n), 32'(flt), 32'(bad));
      check($sformatf("rnd%0d_rdata", n), rd, (bad || wen) ? 32'h0 : ref_load(f3, addr, word));
      check($sformatf("rnd%0d_strobe", n), 32'(seen), 32'(!bad));
      check($sformatf("rnd%0d_bus_ok", n), 32'(ok), 32'd1);
      if (wen && !bad)
        for (int b = 0; b < 4; b++)
          if (ref_mask(f3, addr) & (4'b1 << b)) mem[addr[5:2]][8*b +: 8] = ref_wdata(f3, wd)[8*b +: 8];
    end

    // Reset during WAIT
    @(negedge clk);
    i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_funct3 = F3_LW; i_req_addr = 32'h200;
    @(posedge clk);
    @(negedge clk); i_req_valid = 1'b0; i_dmem_ready = 1'b1;
    @(negedge clk); i_dmem_ready = 1'b0;
    #1;
    check("wait_stall", 32'(o_stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req_ready", 32'(o_req_ready), 32'd1);
    check("arst_outputs", {o_stall, o_resp_valid, o_fault, o_dmem_ren, o_dmem_wen, o_dmem_mask},
          32'd0);
    check("arst_buses", o_dmem_addr | o_dmem_wdata | o_resp_rdata, 32'h0);
    @(negedge clk); rst_n = 1'b1; i_dmem_valid = 1'b1; i_dmem_rdata = 32'h1234_5678;
    norsp = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (o_resp_valid) norsp = 1'b0;
    end
    i_dmem_valid = 1'b0;
    check("no_resp_after_reset", 32'(norsp), 32'd1);

    // Timeout on the short-timeout instance (load never gets valid)
    rst_to_n = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_funct3 = F3_LW; i_req_addr = 32'h40;
    @(posedge clk);
    k = -1; rd = 'x; flt = 1'bx; seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      i_req_valid = 1'b0; i_dmem_valid = 1'b0;
      #1;
      if (to_resp_valid) begin
        k = c; flt = to_fault; rd = to_resp_rdata; seen = to_dmem_ren | to_dmem_wen;
        break;
      end
      i_dmem_ready = to_dmem_ren;
    end
    i_dmem_ready = 1'b0;
    check("to_resp_cycle", 32'(k), 32'(TO_CYCLES + 1));
    check("to_fault", 32'(flt), 32'd1);
    check("to_rdata", rd, 32'h0);
    check("to_strobes_low", 32'(seen), 32'd0);
    @(negedge clk); #1;
    check("to_back_idle", 32'(to_req_ready), 32'd1);
    check("to_resp_done", 32'(to_resp_valid), 32'd0);

    rst_n = 1'b0; rst_to_n = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
